// File: rtl/piso_serializer_if.sv
// Word handshake plus serial output bundle for piso_serializer.
// master drives words in and watches the serial side; slave is the serializer.
interface piso_serializer_if #(
   parameter int unsigned WIDTH = 16
) ();
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             out;
   logic             out_valid;
   logic             frame_start;
   logic             frame_last;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out,
      input  out_valid,
      input  frame_start,
      input  frame_last
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out,
      output out_valid,
      output frame_start,
      output frame_last
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: streams WIDTH-bit words one bit per clock,
// back-to-back words with no idle bits so the receiver's free-running framing stays aligned.
module piso_serializer #(
   parameter int unsigned WIDTH     = 16,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic            clk,
   input logic            reset,
   piso_serializer_if.slave bus
);
   localparam int unsigned     CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic {
      StIdle,
      StShift
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sh;
   logic [CW-1:0]    cnt;
   logic             accept;

   // Ready during the last bit of a word lets the next word follow with zero gap.
   assign bus.in_ready = !reset && ((state == StIdle) || (cnt == LAST));
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= StIdle;
         sh    <= '0;
         cnt   <= '0;
      end else if (accept) begin
         state <= StShift;
         sh    <= bus.in_data;
         cnt   <= '0;
      end else if (state == StShift) begin
         if (cnt == LAST) begin
            state <= StIdle;
            sh    <= '0;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
            if (MSB_FIRST) begin
               sh <= {sh[WIDTH-2:0], 1'b0};
            end else begin
               sh <= {1'b0, sh[WIDTH-1:1]};
            end
         end
      end
   end

   assign bus.out         = (state == StShift) && (MSB_FIRST ? sh[WIDTH-1] : sh[0]);
   assign bus.out_valid   = (state == StShift);
   assign bus.frame_start = (state == StShift) && (cnt == '0);
   assign bus.frame_last  = (state == StShift) && (cnt == LAST);
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a 16-bit MSB-first and an 8-bit LSB-first instance checked
// every cycle against a bit-queue model, with a behavioural receiver reassembling words.
module tb_piso_serializer;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   piso_serializer_if #(.WIDTH(16)) bus16 ();
   piso_serializer_if #(.WIDTH(8))  bus8 ();

   piso_serializer #(.WIDTH(16), .MSB_FIRST(1'b1)) u_dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8)
   );

   logic [15:0] din [2];
   logic        vld [2];
   logic        rdy [2];
   logic        dout [2];
   logic        ovld [2];
   logic        fs [2];
   logic        fl [2];

   assign bus16.in_data  = din[0];
   assign bus16.in_valid = vld[0];
   assign bus8.in_data   = din[1][7:0];
   assign bus8.in_valid  = vld[1];
   assign rdy[0]  = bus16.in_ready;
   assign dout[0] = bus16.out;
   assign ovld[0] = bus16.out_valid;
   assign fs[0]   = bus16.frame_start;
   assign fl[0]   = bus16.frame_last;
   assign rdy[1]  = bus8.in_ready;
   assign dout[1] = bus8.out;
   assign ovld[1] = bus8.out_valid;
   assign fs[1]   = bus8.frame_start;
   assign fl[1]   = bus8.frame_last;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: per instance, a queue of {bit, first, last} still to appear on the serial side.
   // Head of queue is what must be on the wire this cycle; the accept decision for the
   // coming edge is made at the negedge from the model's own occupancy.
   typedef logic [2:0] fq_t[$];
   typedef logic [15:0] wq_t[$];
   fq_t         q [2];
   wq_t         sent [2];
   logic [15:0] rx [2];
   int          rx_n [2];
   bit          acc [2];

   always @(negedge clk or posedge reset) begin
      for (int g = 0; g < 2; g++) begin
         int          w;
         bit          msb;
         logic [2:0]  f;
         logic [15:0] word;
         logic [15:0] mask;
         w    = (g == 0) ? 16 : 8;
         msb  = (g == 0);
         mask = (g == 0) ? 16'hFFFF : 16'h00FF;
         if (reset) begin
            q[g].delete();
            sent[g].delete();
            rx_n[g] = 0;
            acc[g]  = 1'b0;
         end else begin
            f = (q[g].size() != 0) ? q[g][0] : 3'b000;
            check($sformatf("w%0d out_valid", w), 16'(ovld[g]), 16'(q[g].size() != 0));
            check($sformatf("w%0d out", w), 16'(dout[g]), 16'(f[2]));
            check($sformatf("w%0d frame_start", w), 16'(fs[g]), 16'(f[1]));
            check($sformatf("w%0d frame_last", w), 16'(fl[g]), 16'(f[0]));
            check($sformatf("w%0d in_ready", w), 16'(rdy[g]), 16'(q[g].size() <= 1));
            if (ovld[g]) begin
               rx[g] = msb ? {rx[g][14:0], dout[g]} : {dout[g], rx[g][15:1]};
               rx_n[g]++;
               if (rx_n[g] == w) begin
                  rx_n[g] = 0;
                  word = msb ? rx[g] : {8'h00, rx[g][15:8]};
                  check($sformatf("w%0d rx_pending", w), 16'(sent[g].size() != 0), 16'd1);
                  if (sent[g].size() != 0) begin
                     check($sformatf("w%0d rx_word", w), word, sent[g].pop_front());
                  end
               end
            end
            acc[g] = vld[g] && (q[g].size() <= 1);
            if (q[g].size() != 0) void'(q[g].pop_front());
            if (acc[g]) begin
               sent[g].push_back(din[g] & mask);
               for (int i = 0; i < w; i++) begin
                  q[g].push_back({msb ? din[g][w-1-i] : din[g][i], 1'(i == 0), 1'(i == w - 1)});
               end
            end
         end
      end
   end

   // Inputs change 2 time units after the rising edge; acceptance is read from the model.
   task automatic send(input int g, input logic [15:0] w);
      int n;
      n      = 0;
      din[g] = w;
      vld[g] = 1'b1;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!acc[g] && n <= 200);
      check("handshake_timeout", 16'(n > 200), 16'd0);
      @(posedge clk);
      #2;
      vld[g] = 1'b0;
      din[g] = 16'($urandom);
   endtask

   task automatic idle(input int g, input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #2;
         din[g] = 16'($urandom);
      end
   endtask

   task automatic random_phase(input int g, input int iters);
      for (int i = 0; i < iters; i++) begin
         if ($urandom_range(0, 2) != 0) send(g, 16'($urandom));
         else idle(g, $urandom_range(1, 5));
      end
      idle(g, 40);
   endtask

   task automatic run16();
      send(0, 16'hA518);
      idle(0, 20);
      send(0, 16'hA518);
      send(0, 16'h5AE7);
      idle(0, 20);
      send(0, 16'hFFFF);
      send(0, 16'h0000);
      send(0, 16'h8001);
      idle(0, 20);
      // Raise valid at cnt=5 of a word in flight.
      send(0, 16'hC3A5);
      repeat (5) @(posedge clk);
      #2;
      send(0, 16'h0F0F);
      idle(0, 20);
      // Asynchronous reset at cnt=7, between edges.
      send(0, 16'hBEEF);
      repeat (7) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("reset_mid out_valid", 16'(ovld[0]), 16'd0);
      check("reset_mid out", 16'(dout[0]), 16'd0);
      check("reset_mid in_ready", 16'(rdy[0]), 16'd0);
      check("reset_mid frame_start", 16'(fs[0]), 16'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      send(0, 16'h1234);
      idle(0, 20);
      random_phase(0, 300);
   endtask

   task automatic run8();
      send(1, 16'h0001);
      idle(1, 12);
      random_phase(1, 400);
   endtask

   initial begin
      din[0] = '0;
      din[1] = '0;
      vld[0] = 1'b0;
      vld[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", 16'(ovld[0]), 16'd0);
      check("reset out", 16'(dout[0]), 16'd0);
      check("reset in_ready", 16'(rdy[0]), 16'd0);
      check("reset frame_start", 16'(fs[0]), 16'd0);
      check("reset frame_last", 16'(fl[0]), 16'd0);
      check("reset w8 out_valid", 16'(ovld[1]), 16'd0);
      #1;
      reset = 1'b0;
      #1;
      check("post_reset in_ready", 16'(rdy[0]), 16'd1);
      check("post_reset w8 in_ready", 16'(rdy[1]), 16'd1);
      fork
         run16();
         run8();
      join
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, tests=%0d", n_tests);
      $fatal(1);
   end
endmodule
